// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder with ready/valid on both sides.
// One full-adder cell plus a carry flop produce the sum LSB-first over
// WIDTH cycles. The full-width sum and carry-out are then held for the
// consumer until it accepts them.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered signed
// overflow output (ovf).
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// ADD   | one sum bit per clock through the full-adder cell
// DONE  | result presented, out_valid=1, held until out_ready
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0]    cnt;
  logic             c, c_nxt, s_bit;
  logic             cout_r;
  logic             accept, last_bit;

  assign accept   = in_valid && (state == IDLE);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // The single full-adder cell working on the current LSBs.
  assign s_bit = a_sh[0] ^ b_sh[0] ^ c;
  assign c_nxt = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));

  assign sum  = sum_sh;
  assign cout = cout_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; handshake outputs decode from state alone.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ADD;
      end
      ADD: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/sum shift registers, carry flop, bit counter, carry-out capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      c      <= cin;
      cnt    <= '0;
      sum_sh <= '0;
    end else if (state == ADD) begin
      sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      c      <= c_nxt;
      cnt    <= cnt + 1'b1;
      if (last_bit) cout_r <= c_nxt;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_r;
  assign ovf = ovf_r;

  // On the MSB cycle c is the carry into bit WIDTH-1 and c_nxt the carry out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ovf_r <= 1'b0;
    else if (state == ADD && last_bit) ovf_r <= c ^ c_nxt;
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   last_acc = 0;
  int   n_acc   = 0;
  bit   chk_period = 1'b0;
  logic prev_ov = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t     e;
    logic [W:0] t;
    t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s  = t[W-1:0];
    e.co = t[W];
    e.ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Accept monitor: the handshake completes on the coming edge.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(a, b, cin));
      if (chk_period) check("period", 64'(cyc + 1 - acc_cyc), 64'(W + 2));
      last_acc = acc_cyc;
      acc_cyc  = cyc + 1;
      n_acc++;
    end
  end

  // Result monitor: latency on the rising out_valid, scoreboard on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) check("latency", 64'(cyc - acc_cyc), 64'(W));
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sum", 64'(sum), 64'(e.s));
          check("cout", 64'(cout), 64'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
          check("ovf", 64'(ovf), 64'(e.ov));
`endif
        end
      end
    end
  end

  task automatic wait_ready(input string tag);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 100) check({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  // Present operands, wait for the accept edge, then optionally drop in_valid.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input bit hold);
    @(posedge clk); #1;
    a = x; b = y; cin = ci; in_valid = 1'b1;
    wait_ready("accept");
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) break;
    end
    if (k == 200) check("drain_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int acc0;
    exp_t e;
    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 64'(ovf), 64'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Basic sums and carry/overflow corners.
    send(8'h5A, 8'h33, 1'b0, 1'b0);
    wait_idle();
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_idle();
    send(8'h80, 8'h80, 1'b1, 1'b0);
    wait_idle();

    // Backpressure: result held, no new accept while stalled.
    out_ready = 1'b0;
    send(8'h3C, 8'h4B, 1'b1, 1'b1);
    a = 8'h11; b = 8'h22; cin = 1'b0;
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        @(negedge clk);
        if (out_valid) break;
      end
      if (k == 100) check("bp_timeout", 64'(0), 64'(1));
    end
    e = model(8'h3C, 8'h4B, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_sum", 64'(sum), 64'(e.s));
      check("bp_cout", 64'(cout), 64'(e.co));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    check("bp_next_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();

    // Operands wiggle during ADD; only the accept-edge sample matters.
    send(8'h96, 8'h2D, 1'b1, 1'b0);
    repeat (W - 1) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
    end
    wait_idle();

    // Reset in the middle of ADD aborts the operation.
    send(8'hAB, 8'hCD, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_sum", 64'(sum), 64'(0));
    check("abort_cout", 64'(cout), 64'(0));
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'h10, 8'h20, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back with in_valid held high.
    acc0 = n_acc;
    @(posedge clk); #1;
    a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1;
    wait_ready("b2b0");
    @(posedge clk); #1;
    chk_period = 1'b1;
    a = 8'hC3; b = 8'h7E; cin = 1'b1;
    wait_ready("b2b1");
    @(posedge clk); #1;
    a = 8'h7F; b = 8'h01; cin = 1'b0;
    wait_ready("b2b2");
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_period = 1'b0;
    wait_idle();
    check("b2b_accepts", 64'(n_acc - acc0), 64'(3));

    repeat (3) @(negedge clk);
    check("leftover", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
